unidade_controle: RTL

//  Multi-cycle control unit for the 8-bit core. Holds PC and IR, decodes
//  8-bit instructions and drives banco_registradores (ra, rb, rw), the ALU
//  op, the write-back mux select and data-memory strobes. Sits directly

---
 rtl/unidade_controle.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit core: holds PC/IR, sequences
// FETCH/DECODE/EXEC/MEMWB/HALT and drives register-bank and memory strobes.
module unidade_controle #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      instr,
    input  logic [7:0]      reg_rb,
    input  logic            zero,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic [1:0]      ra,
    output logic [1:0]      rb,
    output logic            rw,
    output logic            wb_sel,
    output logic [2:0]      alu_op,
    output logic            mem_re,
    output logic            mem_we,
    output logic            halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMWB  = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_BRZR = 4'd9;
    localparam logic [3:0] OP_JI   = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]      state_r;
    logic [2:0]      state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [7:0]      ir_r;
    logic [3:0]      opcode_s;
    logic            is_alu_s;
    logic [PC_W-1:0] imm_sext_s;
    logic            rw_s;
    logic            mem_re_s;
    logic            mem_we_s;

    assign opcode_s   = ir_r[7:4];
    // Opcodes 0000..0110 are the register-to-register ALU operations
    assign is_alu_s   = (ir_r[7] == 1'b0) && (ir_r[6:4] != 3'b111);
    assign imm_sext_s = {{(PC_W-4){ir_r[3]}}, ir_r[3:0]};

    // Next-state and next-PC selection
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        case (state_r)
            S_FETCH: begin
                pc_nxt_s    = pc_r + PC_ONE;
                state_nxt_s = S_DECODE;
            end
            S_DECODE: begin
                state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
                case (opcode_s)
                    OP_LD: begin
                        state_nxt_s = S_MEMWB;
                    end
                    OP_BRZR: begin
                        state_nxt_s = S_FETCH;
                        if (zero) begin
                            pc_nxt_s = PC_W'(reg_rb);
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end
                    OP_JI: begin
                        state_nxt_s = S_FETCH;
                        pc_nxt_s    = pc_r + imm_sext_s;
                    end
                    OP_HALT: begin
                        state_nxt_s = S_HALT;
                    end
                    default: begin
                        state_nxt_s = S_FETCH;
                    end
                endcase
            end
            S_MEMWB: begin
                state_nxt_s = S_FETCH;
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

    // State, PC and IR registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            if (state_r == S_FETCH) begin
                ir_r <= instr;
            end
        end
    end

    // Strobe decode; a low reset kills every write/read strobe in the same cycle
    always_comb begin
        rw_s     = 1'b0;
        mem_re_s = 1'b0;
        mem_we_s = 1'b0;
        if (reset) begin
            case (state_r)
                S_EXEC: begin
                    rw_s     = is_alu_s;
                    mem_re_s = (opcode_s == OP_LD);
                    mem_we_s = (opcode_s == OP_ST);
                end
                S_MEMWB: begin
                    rw_s = 1'b1;
                end
                default: begin
                    rw_s = 1'b0;
                end
            endcase
        end else begin
            rw_s     = 1'b0;
            mem_re_s = 1'b0;
            mem_we_s = 1'b0;
        end
    end

    assign pc     = pc_r;
    assign ir     = ir_r;
    assign ra     = ir_r[3:2];
    assign rb     = ir_r[1:0];
    assign alu_op = ir_r[6:4];
    assign rw     = rw_s;
    assign mem_re = mem_re_s;
    assign mem_we = mem_we_s;
    assign wb_sel = (state_r == S_MEMWB);
    assign halted = (state_r == S_HALT);

endmodule
